// File: rtl/pipeline_ctrl.sv
// Pipeline hazard / memory-wait controller: Mealy stall, flush and bubble control with a bounded memory wait.
// Optional PIPELINE_CTRL_PERF_EN adds saturating stall_cycles / flush_count counters.
module pipeline_ctrl #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_MemRead,
  input  logic       mem_MemRead,
  input  logic       mem_MemWrite,
  input  logic       mem_branch_taken,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       id_ex_write,
  output logic       ex_mem_write,
  output logic       id_ex_bubble,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       flush_ex_mem,
  output logic       mem_req,
  output logic       mem_err,
  output logic [1:0] state
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [1:0] {RUN = 2'b00, MEMWAIT = 2'b01, ERROR = 2'b10} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

  state_t     st;
  logic [7:0] wait_cnt;
  logic       mem_acc, mem_stall, load_use, branch_fire;

  assign mem_acc     = mem_MemRead | mem_MemWrite;
  assign mem_stall   = mem_acc & ~mem_ready;
  assign load_use    = ex_MemRead && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign branch_fire = !reset && (st == RUN) && !mem_stall && mem_branch_taken;
  assign state       = st;

  // Outputs follow the current inputs; reset forces everything quiet even between edges.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_write  = 1'b0;
    ex_mem_write = 1'b0;
    id_ex_bubble = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    mem_req      = 1'b0;
    mem_err      = 1'b0;
    if (!reset) begin
      case (st)
        RUN: begin
          mem_req = mem_acc;
          if (!mem_stall) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            if (mem_branch_taken) begin
              flush_if_id  = 1'b1;
              flush_id_ex  = 1'b1;
              flush_ex_mem = 1'b1;
            end else if (load_use) begin
              pc_write     = 1'b0;
              if_id_write  = 1'b0;
              id_ex_bubble = 1'b1;
            end
          end
        end
        MEMWAIT: begin
          mem_req      = 1'b1;
          pc_write     = mem_ready;
          if_id_write  = mem_ready;
          id_ex_write  = mem_ready;
          ex_mem_write = mem_ready;
        end
        default: mem_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      case (st)
        RUN: begin
          wait_cnt <= 8'd0;
          if (mem_stall) st <= MEMWAIT;
        end
        MEMWAIT: begin
          if (mem_ready) begin
            st       <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt >= LAST_WAIT) begin
            st <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ERROR:   st <= ERROR;
        default: st <= ERROR;
      endcase
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_count  <= 16'd0;
    end else begin
      if (!pc_write && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
      if (branch_fire && flush_count != 16'hFFFF)     flush_count  <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_pipeline_ctrl;
  localparam int WL = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic ex_MemRead = 0, mem_MemRead = 0, mem_MemWrite = 0, mem_branch_taken = 0, mem_ready = 0;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble;
  logic flush_if_id, flush_id_ex, flush_ex_mem, mem_req, mem_err;
  logic [1:0] state;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  pipeline_ctrl #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_branch_taken(mem_branch_taken), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .id_ex_bubble(id_ex_bubble), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem), .mem_req(mem_req),
    .mem_err(mem_err), .state(state)
`ifdef PIPELINE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  bit m_wait = 0, m_err = 0;
  int m_stalled = 0;

  logic [11:0] obs_v;
  assign obs_v = {pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
                  flush_if_id, flush_id_ex, flush_ex_mem, mem_req, mem_err, state};

  // Expected {4 enables, bubble, 3 flushes, mem_req, mem_err, state}
  function automatic logic [11:0] model_out();
    logic acc, lu;
    acc = mem_MemRead | mem_MemWrite;
    lu  = ex_MemRead && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    if (reset) return 12'b0;
    if (m_err) return {8'b0, 1'b0, 1'b1, 2'b10};
    if (m_wait) return {{4{mem_ready}}, 4'b0, 1'b1, 1'b0, 2'b01};
    if (acc && !mem_ready) return {8'b0, 1'b1, 1'b0, 2'b00};
    if (mem_branch_taken) return {4'b1111, 1'b0, 3'b111, acc, 1'b0, 2'b00};
    if (lu) return {4'b0011, 1'b1, 3'b000, acc, 1'b0, 2'b00};
    return {4'b1111, 4'b0, acc, 1'b0, 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle(input string tag);
    if (reset) begin m_wait = 0; m_err = 0; m_stalled = 0; end
    #1 chk(tag, 32'(obs_v), 32'(model_out()));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset && !m_err) begin
      if (m_wait) begin
        if (mem_ready) m_wait = 0;
        else begin
          m_stalled++;
          if (m_stalled == WL) begin m_err = 1; m_wait = 0; end
        end
      end else if ((mem_MemRead | mem_MemWrite) && !mem_ready) begin
        m_wait = 1; m_stalled = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle(input string tag);
    settle(tag);
    tick();
  endtask

  task automatic clr();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_MemRead = 0; mem_MemRead = 0;
    mem_MemWrite = 0; mem_branch_taken = 0; mem_ready = 0;
  endtask

  initial begin
    @(negedge clk);
    settle("reset_out");
    chk("reset_state", 32'(state), 32'd0);
    tick();
    reset = 0;
    cycle("idle");

`ifdef PIPELINE_CTRL_PERF_EN
    id_rs1 = 3; id_rs2 = 5; ex_rd = 5; ex_MemRead = 1;
    cycle("perf_lu1");
    clr(); cycle("perf_gap");
    id_rs1 = 5; ex_rd = 5; ex_MemRead = 1;
    cycle("perf_lu2");
    clr(); mem_branch_taken = 1;
    cycle("perf_br");
    clr(); settle("perf_idle");
    chk("perf_stall_cycles", stall_cycles, 32'd2);
    chk("perf_flush_count", 32'(flush_count), 32'd1);
    tick();
`endif

    // load-use on rs2
    id_rs1 = 3; id_rs2 = 5; ex_rd = 5; ex_MemRead = 1;
    settle("lu");
    chk("lu_ctrl", 32'({pc_write, if_id_write, id_ex_bubble}), 32'b001);
    tick();
    clr(); cycle("lu_after");
    // ex_rd = x0 never stalls
    ex_MemRead = 1; ex_rd = 0; id_rs2 = 0;
    settle("lu_x0");
    chk("lu_x0_pc", 32'(pc_write), 32'd1);
    tick();
    // branch beats load-use
    id_rs1 = 7; ex_rd = 7; ex_MemRead = 1; mem_branch_taken = 1;
    settle("br_lu");
    chk("br_ctrl", 32'({flush_if_id, flush_id_ex, flush_ex_mem, pc_write, id_ex_bubble}), 32'b11110);
    tick();
    clr();

    // memory wait: stall cycle in RUN, three frozen MEMWAIT cycles, then ready
    mem_MemRead = 1;
    cycle("mw_run_stall");
    for (int i = 0; i < 3; i++) begin
      settle("mw_wait");
      chk("mw_state", 32'(state), 32'd1);
      tick();
    end
    mem_ready = 1;
    settle("mw_ready");
    chk("mw_ready_en", 32'({pc_write, if_id_write, id_ex_write, ex_mem_write}), 32'hF);
    tick();
    clr();
    settle("mw_back");
    chk("mw_back_state", 32'(state), 32'd0);
    tick();

    // timeout
    mem_MemRead = 1;
    cycle("to_run");
    for (int i = 0; i < WL; i++) cycle("to_wait");
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2); mem_branch_taken = 1;
      settle("to_err");
      chk("to_err_bits", 32'({state, mem_err, pc_write, mem_req}), 32'b10100);
      tick();
    end
    clr();

    // reset mid-MEMWAIT
    reset = 1; cycle("rst_err");
    reset = 0;
    mem_MemRead = 1;
    cycle("rm_run");
    cycle("rm_wait1");
    reset = 1;
    settle("rm_async");
    chk("rm_async_state", 32'(state), 32'd0);
    tick();
    reset = 0; mem_ready = 1;
    settle("rm_release");
    chk("rm_release_state", 32'(state), 32'd0);
    tick();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      id_rs1 = 5'($urandom_range(0, 7));
      id_rs2 = 5'($urandom_range(0, 7));
      ex_rd = 5'($urandom_range(0, 7));
      ex_MemRead = ($urandom_range(0, 1) == 1);
      mem_MemRead = ($urandom_range(0, 3) == 0);
      mem_MemWrite = ($urandom_range(0, 5) == 0);
      mem_branch_taken = ($urandom_range(0, 4) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 39) == 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_LIMIT, default 16, meaning the maximum number of consecutive MEMWAIT cycles without mem_ready before ERROR (legal range 2..256).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-005 ex_rd  in  5; ex_MemRead  in  1  destination register and load flag of the instruction in EX.
REQ-006 mem_MemRead, mem_MemWrite  in  1 each  memory-access flags of the EX/MEM register contents.
REQ-007 mem_branch_taken  in  1  branch resolved taken in MEM.
REQ-008 mem_ready  in  1  data-memory completion handshake.
REQ-009 pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  register update enables.
REQ-010 id_ex_bubble  out  1  load NOP controls into ID/EX.
REQ-011 flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  clear the named pipeline register.
REQ-012 mem_req  out  1  data-memory request; mem_err  out  1  sticky timeout flag; state  out  2  current FSM state.

Function
REQ-013 FSM states SHALL be RUN=00, MEMWAIT=01, ERROR=10; 11 SHALL be unreachable and SHALL map to ERROR on the next edge.
REQ-014 Outputs SHALL be combinational from state and current inputs (Mealy); state and wait counter SHALL be registered.
REQ-015 Defaults in RUN: all four write enables=1, bubble/flushes=0, mem_req=mem_MemRead|mem_MemWrite, mem_err=0.
REQ-016 RUN, priority 1 (mem stall): mem_req=1 and mem_ready=0 -> all write enables=0, no bubble, no flush; next state MEMWAIT, counter=0.
REQ-017 RUN, priority 2 (branch): mem_branch_taken=1 -> flush_if_id=flush_id_ex=flush_ex_mem=1, pc_write=1, id_ex_bubble=0; stay RUN.
REQ-018 RUN, priority 3 (load-use): ex_MemRead=1, ex_rd!=0, ex_rd equals id_rs1 or id_rs2 -> pc_write=0, if_id_write=0, id_ex_bubble=1; stay RUN.
REQ-019 Rule 3 SHALL NOT fire when rule 1 or 2 fires; rule 2 SHALL NOT fire when rule 1 fires.
REQ-020 MEMWAIT: mem_req=1; mem_ready=0 -> all write enables=0, counter+1; mem_ready=1 -> all write enables=1, next RUN, counter=0.
REQ-021 MEMWAIT with counter==WAIT_LIMIT-1 and mem_ready=0 SHALL go to ERROR (exactly WAIT_LIMIT stalled cycles).
REQ-022 Load-use and branch inputs SHALL be ignored in MEMWAIT; pipeline stays frozen.
REQ-023 ERROR: all write enables, mem_req, bubble, flushes=0; mem_err=1; exit only by reset.
REQ-024 Wait counter SHALL be 8 bits and SHALL never wrap.

Reset
REQ-025 Reset assertion SHALL immediately force state=RUN, counter=0, and, while reset is high, all write enables, bubble, flushes, mem_req and mem_err=0.
REQ-026 Reset asserted mid-MEMWAIT or in ERROR SHALL abandon the access; first cycle after release follows RUN rules.

Configuration
REQ-027 With macro PIPELINE_CTRL_PERF_EN defined, the block SHALL add outputs stall_cycles (32 bits, counts cycles where pc_write=0 outside reset) and flush_count (16 bits, counts rule-2 firings), both saturating, cleared by reset.
REQ-028 Without PIPELINE_CTRL_PERF_EN, those ports and counters SHALL be absent and all other behaviour identical.

Verification
REQ-029 Load-use: ex_MemRead=1, ex_rd=5, id_rs2=5 -> one cycle pc_write=0, if_id_write=0, id_ex_bubble=1; ex_rd=0 -> no stall.
REQ-030 Branch: mem_branch_taken=1 with concurrent load-use -> three flushes=1, pc_write=1, id_ex_bubble=0.
REQ-031 Memory wait: mem_MemRead=1, mem_ready low 3 cycles then high -> 3 frozen cycles (state=01), enables=1 on ready cycle, state=00 next.
REQ-032 Timeout: WAIT_LIMIT=4, mem_ready held 0 -> RUN stall cycle, 4 MEMWAIT cycles, then state=10, mem_err=1, all enables=0 until reset.
REQ-033 Reset mid-MEMWAIT: reset pulsed on 2nd wait cycle -> outputs 0 immediately, state=00 after release, counter=0.
REQ-034 PERF_EN: 2 load-use stalls + 1 branch -> stall_cycles=2, flush_count=1; forced near-max values saturate, not wrap.
